// File: rtl/sprite_rle_loader.sv
// sprite_rle_loader
// Decodes a run-length-encoded palette-index stream and fills one sprite image
// (IMAGE_WIDTH*IMAGE_HEIGHT pixels, row-major from base_addr) through the RAM
// write port, one pixel per clock.
//
// Ports:
//   Clk, Reset            clock and synchronous active-high reset
//   load, base_addr       start pulse (taken only in IDLE) and first RAM word
//   in_valid/in_ready     token handshake; in_run = run length - 1, in_index = colour
//   write_address,
//   data_In, we           RAM write port (address/data forced to 0 when we=0)
//   busy, done, err       in progress, one-cycle completion pulse, sticky overrun
//
// Optional feature: define SPRITE_RLE_SKIP_TRANSPARENT_EN to suppress writes of
// palette index 0, so transparent pixels leave the existing RAM contents intact.
module sprite_rle_loader #(
    parameter int IMAGE_WIDTH  = 36,
    parameter int IMAGE_HEIGHT = 40,
    parameter int DATA_W       = 5,
    parameter int ADDR_W       = 19,
    parameter int RUN_W        = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RUN_W-1:0]  in_run,
    input  logic [DATA_W-1:0] in_index,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] data_In,
    output logic              we,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int TOTAL = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TOKEN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [RUN_W:0]    run_left_q, run_left_d;   // one extra bit so 255+1 does not wrap
    logic [DATA_W-1:0] idx_q, idx_d;

    logic [CNT_W-1:0]  count_inc;
    logic [RUN_W:0]    run_dec;

    assign count_inc = count_q + 1'b1;
    assign run_dec   = run_left_q - 1'b1;
    assign err       = err_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Datapath registers are only read in states entered after they are loaded.
    always_ff @(posedge Clk) begin
        base_q     <= base_d;
        run_left_q <= run_left_d;
        idx_q      <= idx_d;
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        err_d         = err_q;
        base_d        = base_q;
        run_left_d    = run_left_q;
        idx_d         = idx_q;
        in_ready      = 1'b0;
        we            = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        write_address = '0;
        data_In       = '0;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    base_d  = base_addr;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = S_TOKEN;
                end
            end
            S_TOKEN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    run_left_d = {1'b0, in_run} + 1'b1;
                    idx_d      = in_index;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                busy = 1'b1;
`ifdef SPRITE_RLE_SKIP_TRANSPARENT_EN
                we   = (idx_q != '0);
`else
                we   = 1'b1;
`endif
                if (we) begin
                    write_address = base_q + ADDR_W'(count_q);
                    data_In       = idx_q;
                end
                count_d    = count_inc;
                run_left_d = run_dec;
                // Image full takes priority; any pixels still owed are an overrun.
                if (count_inc == TOTAL_C) begin
                    if (run_dec != '0) begin
                        err_d = 1'b1;
                    end
                    state_d = S_DONE;
                end else if (run_dec == '0) begin
                    state_d = S_TOKEN;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sprite_rle_loader.sv
module tb_sprite_rle_loader;

    localparam int IMAGE_WIDTH  = 36;
    localparam int IMAGE_HEIGHT = 40;
    localparam int DATA_W       = 5;
    localparam int ADDR_W       = 19;
    localparam int RUN_W        = 8;
    localparam int TOTAL        = IMAGE_WIDTH * IMAGE_HEIGHT;

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              load = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [RUN_W-1:0]  in_run = '0;
    logic [DATA_W-1:0] in_index = '0;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] data_In;
    logic              we;
    logic              busy;
    logic              done;
    logic              err;

    sprite_rle_loader #(
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .IMAGE_HEIGHT(IMAGE_HEIGHT),
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .RUN_W       (RUN_W)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .load         (load),
        .base_addr    (base_addr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_run       (in_run),
        .in_index     (in_index),
        .write_address(write_address),
        .data_In      (data_In),
        .we           (we),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t sb[$];
    int  tok_run[$];
    int  tok_idx[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  done_cnt = 0;
    bit  exp_err = 0;
    bit  exp_last_written = 1;
    bit  prev_we = 0;

    function automatic void chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endfunction

    // Reference model: expand runs into a pixel list, cut at TOTAL.
    task automatic build_expect(input logic [ADDR_W-1:0] base);
        int  p;
        bit  skip;
        wr_t w;
        p = 0;
        exp_err = 0;
        exp_last_written = 1;
        for (int t = 0; t < tok_run.size(); t++) begin
            for (int k = 0; k <= tok_run[t]; k++) begin
                if (p == TOTAL) begin
                    exp_err = 1;
                    break;
                end
`ifdef SPRITE_RLE_SKIP_TRANSPARENT_EN
                skip = (tok_idx[t] == 0);
`else
                skip = 0;
`endif
                if (!skip) begin
                    w.a = base + ADDR_W'(p);
                    w.d = DATA_W'(tok_idx[t]);
                    sb.push_back(w);
                end
                exp_last_written = !skip;
                p++;
            end
        end
    endtask

    task automatic gen_random_tail(input bit allow_zero_idx);
        int sum;
        int r;
        sum = 0;
        foreach (tok_run[i]) sum += tok_run[i] + 1;
        while (sum < TOTAL) begin
            if (TOTAL - sum <= 256 && $urandom_range(0, 1) == 1) r = TOTAL - sum - 1;
            else if ($urandom_range(0, 3) == 0) r = $urandom_range(0, 3);
            else r = $urandom_range(0, 255);
            tok_run.push_back(r);
            if (allow_zero_idx && $urandom_range(0, 3) == 0) tok_idx.push_back(0);
            else tok_idx.push_back($urandom_range(1, 31));
            sum += r + 1;
        end
    endtask

    // Monitor: pops the scoreboard on every RAM write.
    always @(negedge Clk) begin
        wr_t e;
        if (we) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", write_address, e.a);
                chk("wr_data", data_In, e.d);
            end
        end else begin
            chk("idle_addr_zero", write_address, 0);
            chk("idle_data_zero", data_In, 0);
        end
        if (done) begin
            done_cnt++;
            if (exp_last_written) chk("done_after_last_write", prev_we, 1);
            chk("ready_in_done", in_ready, 0);
            chk("busy_in_done", busy, 0);
        end
        prev_we = we;
    end

    task automatic do_fill(input logic [ADDR_W-1:0] base, input bit gaps);
        int i;
        int g;
        int w;
        int last_run;
        int exp_w;
        build_expect(base);
        done_cnt = 0;
        @(negedge Clk);
        load = 1'b1;
        base_addr = base;
        @(negedge Clk);
        load = 1'b0;
        base_addr = $urandom;
        i = 0;
        last_run = -1;
        while (i < tok_run.size() && busy) begin
            g = gaps ? $urandom_range(0, 3) : 0;
            repeat (g) begin
                in_valid = 1'b0;
                @(negedge Clk);
            end
            in_valid = 1'b1;
            in_run   = RUN_W'(tok_run[i]);
            in_index = DATA_W'(tok_idx[i]);
            w = 0;
            while (!in_ready && busy && w < 2000) begin
                @(negedge Clk);
                w++;
            end
            if (w >= 2000) begin
                chk("token_wait_timeout", w, 0);
                break;
            end
            if (!busy) break;
            if (last_run >= 0) begin
                exp_w = last_run + 1 - g;
                if (exp_w < 0) exp_w = 0;
                chk("token_wait_cycles", w, exp_w);
            end
            last_run = tok_run[i];
            i++;
            @(negedge Clk);
            in_valid = 1'b0;
        end
        in_valid = 1'b0;
        w = 0;
        while (busy && w < 3000) begin
            @(negedge Clk);
            w++;
        end
        chk("fill_finish_timeout", (w >= 3000), 0);
        repeat (3) @(negedge Clk);
        chk("done_pulses", done_cnt, 1);
        chk("writes_left", sb.size(), 0);
        chk("err_flag", err, exp_err);
        chk("busy_after", busy, 0);
        sb.delete();
    endtask

    initial begin
        #(600000 * 10);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a coincident load: load must be ignored.
        Reset = 1'b1;
        load = 1'b1;
        base_addr = 19'h123;
        repeat (2) @(negedge Clk);
        chk("rst_we", we, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        Reset = 1'b0;
        load = 1'b0;
        @(negedge Clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ready", in_ready, 0);

        // Nominal fill at 0x100.
        tok_run.delete(); tok_idx.delete();
        repeat (5) begin tok_run.push_back(255); tok_idx.push_back(3); end
        tok_run.push_back(159); tok_idx.push_back(7);
        do_fill(19'h100, 0);

        // Overrun: 1500 pixels offered.
        tok_run.delete(); tok_idx.delete();
        repeat (5) begin tok_run.push_back(255); tok_idx.push_back(1); end
        tok_run.push_back(219); tok_idx.push_back(2);
        do_fill(19'h2000, 1);

        // Backpressure: valid held high through a (9,4) run.
        tok_run.delete(); tok_idx.delete();
        tok_run.push_back(9); tok_idx.push_back(4);
        tok_run.push_back(2); tok_idx.push_back(6);
        gen_random_tail(0);
        do_fill(19'h0, 0);

        // Transparent run followed by a single pixel.
        tok_run.delete(); tok_idx.delete();
        tok_run.push_back(9); tok_idx.push_back(0);
        tok_run.push_back(0); tok_idx.push_back(5);
        gen_random_tail(1);
        do_fill(19'h0, 1);

        // Reset in the 101st write cycle, with an ignored load while busy.
        tok_run.delete(); tok_idx.delete();
        tok_run.push_back(255); tok_idx.push_back(6);
        build_expect(19'h0);
        @(negedge Clk);
        load = 1'b1;
        base_addr = 19'h0;
        @(negedge Clk);
        load = 1'b0;
        chk("mid_ready", in_ready, 1);
        in_valid = 1'b1;
        in_run   = 8'd255;
        in_index = 5'd6;
        repeat (50) begin
            @(negedge Clk);
            in_valid = 1'b0;
        end
        load = 1'b1;
        base_addr = 19'h5555;
        @(negedge Clk);
        load = 1'b0;
        repeat (50) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("mid_rst_we", we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_writes_seen", sb.size(), 256 - 101);
        sb.delete();
        tok_run.delete(); tok_idx.delete();
        gen_random_tail(0);
        do_fill(19'h0, 1);

        // Random fills, including an address range that wraps.
        for (int n = 0; n < 3; n++) begin
            tok_run.delete(); tok_idx.delete();
            gen_random_tail(1);
            if (n == 0) do_fill(19'h7FF00, 1);
            else do_fill(ADDR_W'($urandom), n[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
